// File: rtl/dll_pkg.sv
// Shared definitions for the DLL lock sequencer.
//   - FSM state encoding (also exported on the debug `state` port)
//   - Division ratio / trim / tick counter widths
//   - Latched configuration record and expected-tick helper
package dll_pkg;

    localparam int DIV_W  = 8;
    localparam int TRIM_W = 26;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_DCO_RUN = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } dll_state_e;

    // Configuration captured when leaving IDLE.
    typedef struct packed {
        logic              dco;
        logic [DIV_W-1:0]  div;
        logic [TRIM_W-1:0] trim;
    } dll_cfg_t;

    // Ticks expected in one window: (div << win_log2) >> presc_log2,
    // evaluated at the tick counter width so the result matches the counter.
    function automatic logic [CNT_W-1:0] expected_ticks(input logic [DIV_W-1:0] div,
                                                        input int win_log2,
                                                        input int presc_log2);
        logic [CNT_W-1:0] scaled;
        scaled = CNT_W'(div) << win_log2;
        return scaled >> presc_log2;
    endfunction

endpackage

// File: rtl/dll_freq_meter.sv
// Feedback frequency meter for the DLL lock sequencer.
// Counts fb_tick pulses over back-to-back windows of 2^WIN_LOG2 clocks and
// compares each window's total against `expected` with +/-TOL slack.
// Ports:
//   clock, resetb : reference clock, synchronous active-low reset
//   clear         : hold timer and counter at zero (not measuring)
//   fb_tick       : one-cycle feedback tick
//   expected      : target ticks per window
//   win_done      : one-cycle pulse on the final cycle of each window
//   win_good      : window total within tolerance (valid with win_done)
module dll_freq_meter
    import dll_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    parameter int TOL      = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             clear,
    input  logic             fb_tick,
    input  logic [CNT_W-1:0] expected,
    output logic             win_done,
    output logic             win_good
);

    logic [WIN_LOG2-1:0] timer;
    logic [CNT_W-1:0]    tick_cnt;
    logic [CNT_W-1:0]    cnt_now;
    logic [CNT_W-1:0]    err;
    logic                win_last;

    always_comb begin
        win_last = &timer;
        // A tick in the final cycle still belongs to the ending window, so the
        // verdict is formed on the count including this cycle's tick.
        cnt_now  = (fb_tick && (tick_cnt != '1)) ? tick_cnt + 1'b1 : tick_cnt;
        err      = (cnt_now >= expected) ? cnt_now - expected : expected - cnt_now;
        win_good = (err <= CNT_W'(TOL));
        win_done = win_last && !clear;
    end

    always_ff @(posedge clock) begin
        if (!resetb || clear) begin
            timer    <= '0;
            tick_cnt <= '0;
        end else begin
            timer    <= timer + 1'b1;
            tick_cnt <= win_last ? '0 : cnt_now;
        end
    end

endmodule

// File: rtl/dll_lock_sequencer.sv
// Bring-up and lock supervisor for the digital DLL.
// Sequences DLL reset/enable/mode, latches division ratio and trim, measures
// the feedback frequency and reports lock or acquire timeout.
// Ports:
//   clock, resetb : reference clock, synchronous active-low reset
//   start         : level run request; dropping it aborts to IDLE
//   cfg_dco       : 1 = open-loop DCO mode
//   cfg_div       : feedback division ratio
//   cfg_trim      : external trim for DCO mode
//   fb_tick       : prescaled feedback tick, synchronous to clock
//   dll_resetb    : DLL reset (active low)
//   dll_enable    : DLL enable
//   dll_dco       : DLL DCO-mode select
//   dll_div       : latched division ratio
//   dll_ext_trim  : latched trim
//   locked        : frequency within tolerance
//   fault         : acquire timeout
//   state         : FSM state for debug
module dll_lock_sequencer
    import dll_pkg::*;
#(
    parameter int RST_CYC    = 16,
    parameter int WIN_LOG2   = 8,
    parameter int PRESC_LOG2 = 4,
    parameter int TOL        = 2,
    parameter int LOCK_WINS  = 4,
    parameter int LOSS_WINS  = 2,
    parameter int MAX_WINS   = 64
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    input  logic              cfg_dco,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [TRIM_W-1:0] cfg_trim,
    input  logic              fb_tick,
    output logic              dll_resetb,
    output logic              dll_enable,
    output logic              dll_dco,
    output logic [DIV_W-1:0]  dll_div,
    output logic [TRIM_W-1:0] dll_ext_trim,
    output logic              locked,
    output logic              fault,
    output logic [2:0]        state
);

    localparam int HOLD_W = $clog2(RST_CYC + 1);
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);
    localparam int BAD_W  = $clog2(LOSS_WINS + 1);
    localparam int WINC_W = $clog2(MAX_WINS + 1);

    dll_state_e        cur_state, nxt_state;
    dll_cfg_t          cfg_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [WINC_W-1:0] win_cnt;
    logic              meter_clr;
    logic              win_done;
    logic              win_good;
    logic [CNT_W-1:0]  expected;

    assign expected     = expected_ticks(cfg_q.div, WIN_LOG2, PRESC_LOG2);
    assign dll_div      = cfg_q.div;
    assign dll_ext_trim = cfg_q.trim;
    assign state        = cur_state;

    dll_freq_meter #(
        .WIN_LOG2 (WIN_LOG2),
        .TOL      (TOL)
    ) u_meter (
        .clock    (clock),
        .resetb   (resetb),
        .clear    (meter_clr),
        .fb_tick  (fb_tick),
        .expected (expected),
        .win_done (win_done),
        .win_good (win_good)
    );

    // Next state and Moore outputs.
    always_comb begin
        nxt_state  = cur_state;
        dll_resetb = 1'b0;
        dll_enable = 1'b0;
        dll_dco    = 1'b0;
        locked     = 1'b0;
        fault      = 1'b0;
        meter_clr  = 1'b1;
        case (cur_state)
            ST_IDLE: begin
                if (start) nxt_state = ST_HOLD;
            end
            ST_HOLD: begin
                dll_enable = 1'b1;
                dll_dco    = cfg_q.dco;
                if (hold_cnt == HOLD_W'(RST_CYC - 1))
                    nxt_state = cfg_q.dco ? ST_DCO_RUN : ST_ACQUIRE;
            end
            ST_DCO_RUN: begin
                dll_resetb = 1'b1;
                dll_enable = 1'b1;
                dll_dco    = 1'b1;
            end
            ST_ACQUIRE: begin
                dll_resetb = 1'b1;
                dll_enable = 1'b1;
                meter_clr  = 1'b0;
                // Lock wins over timeout when both land on the same window.
                if (win_done) begin
                    if (win_good && (good_cnt == GOOD_W'(LOCK_WINS - 1)))
                        nxt_state = ST_LOCKED;
                    else if (win_cnt == WINC_W'(MAX_WINS - 1))
                        nxt_state = ST_FAULT;
                end
            end
            ST_LOCKED: begin
                dll_resetb = 1'b1;
                dll_enable = 1'b1;
                locked     = 1'b1;
                meter_clr  = 1'b0;
                if (win_done && !win_good && (bad_cnt == BAD_W'(LOSS_WINS - 1)))
                    nxt_state = ST_ACQUIRE;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: nxt_state = ST_IDLE;
        endcase
        // Dropping start aborts from anywhere, mid-window included.
        if (!start) nxt_state = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            cur_state <= ST_IDLE;
            cfg_q     <= '0;
            hold_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            win_cnt   <= '0;
        end else begin
            cur_state <= nxt_state;

            // Config is visible only outside IDLE; captured once per run.
            if (nxt_state == ST_IDLE)
                cfg_q <= '0;
            else if (cur_state == ST_IDLE)
                cfg_q <= '{dco: cfg_dco, div: cfg_div, trim: cfg_trim};

            hold_cnt <= ((cur_state == ST_HOLD) && (nxt_state == ST_HOLD)) ?
                        hold_cnt + 1'b1 : '0;

            // Window bookkeeping restarts on every state change; the meter
            // timer itself keeps running across ACQUIRE<->LOCKED since those
            // changes only happen on a window boundary.
            if (nxt_state != cur_state) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
                win_cnt  <= '0;
            end else if (win_done) begin
                if (cur_state == ST_ACQUIRE) begin
                    win_cnt  <= win_cnt + 1'b1;
                    good_cnt <= win_good ? good_cnt + 1'b1 : '0;
                end else begin
                    bad_cnt  <= win_good ? '0 : bad_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dll_lock_sequencer.sv
module tb_dll_lock_sequencer;

    localparam int RST_CYC    = 16;
    localparam int WIN        = 256;
    localparam int PRESC_LOG2 = 4;
    localparam int TOL        = 2;
    localparam int LOCK_WINS  = 4;
    localparam int LOSS_WINS  = 2;
    localparam int MAX_WINS   = 64;

    localparam logic [2:0] S_IDLE = 3'd0, S_HOLD = 3'd1, S_DCO = 3'd2,
                           S_ACQ = 3'd3, S_LOCK = 3'd4, S_FAULT = 3'd5;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic        cfg_dco = 1'b0;
    logic [7:0]  cfg_div = '0;
    logic [25:0] cfg_trim = '0;
    logic        fb_tick = 1'b0;
    logic        dll_resetb, dll_enable, dll_dco, locked, fault;
    logic [7:0]  dll_div;
    logic [25:0] dll_ext_trim;
    logic [2:0]  state;

    dll_lock_sequencer dut (
        .clock(clock), .resetb(resetb), .start(start), .cfg_dco(cfg_dco),
        .cfg_div(cfg_div), .cfg_trim(cfg_trim), .fb_tick(fb_tick),
        .dll_resetb(dll_resetb), .dll_enable(dll_enable), .dll_dco(dll_dco),
        .dll_div(dll_div), .dll_ext_trim(dll_ext_trim), .locked(locked),
        .fault(fault), .state(state)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int          rel;
        logic [2:0]  st;
        logic        rstb, en, dco, lk, flt;
        logic [7:0]  div;
        logic [25:0] trim;
    } ev_t;

    ev_t  sb[$];
    ev_t  mon_e;
    int   n_chk = 0, n_fail = 0;
    int   e0 = 0;
    bit   mon_en = 0;
    logic [2:0] prev_st = 3'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected visible outputs for a state, straight from the state table.
    function automatic ev_t mk_ev(input int rel, input logic [2:0] st, input bit dco,
                                  input logic [7:0] div, input logic [25:0] trim);
        ev_t e;
        e.rel = rel; e.st = st;
        e.rstb = 0; e.en = 0; e.dco = 0; e.lk = 0; e.flt = 0;
        e.div = (st == S_IDLE) ? 8'd0 : div;
        e.trim = (st == S_IDLE) ? 26'd0 : trim;
        case (st)
            S_HOLD:  begin e.en = 1; e.dco = dco; end
            S_DCO:   begin e.rstb = 1; e.en = 1; e.dco = 1; end
            S_ACQ:   begin e.rstb = 1; e.en = 1; end
            S_LOCK:  begin e.rstb = 1; e.en = 1; e.lk = 1; end
            S_FAULT: begin e.flt = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: every observed state change must match the scoreboard head.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("lock_fault_excl", 64'(locked & fault), 64'd0);
            if (state !== prev_st) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_transition: got state %0d at rel %0d, expected none", state, cyc - e0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("state", 64'(state), 64'(mon_e.st));
                    chk("transition_cycle", 64'(cyc - e0), 64'(mon_e.rel));
                    chk("dll_resetb", 64'(dll_resetb), 64'(mon_e.rstb));
                    chk("dll_enable", 64'(dll_enable), 64'(mon_e.en));
                    chk("dll_dco", 64'(dll_dco), 64'(mon_e.dco));
                    chk("locked", 64'(locked), 64'(mon_e.lk));
                    chk("fault", 64'(fault), 64'(mon_e.flt));
                    chk("dll_div", 64'(dll_div), 64'(mon_e.div));
                    chk("dll_ext_trim", 64'(dll_ext_trim), 64'(mon_e.trim));
                end
                prev_st = state;
            end
        end
    end

    // One run: model the window verdicts, queue the expected transitions,
    // then drive start/fb_tick so window k carries exactly cnts[k] ticks.
    task automatic run_scen(input bit dco, input logic [7:0] div, input logic [25:0] trim,
                            input int cnts[$], input int abort_rel);
        bit tk[$];
        bit w[WIN];
        bit t, good, lk;
        int expv, rel, err, run, bad, nw, j;
        expv = ((int'(div) * WIN) % 65536) / (1 << PRESC_LOG2);
        sb.push_back(mk_ev(0, S_HOLD, dco, div, trim));
        if (abort_rel > RST_CYC) begin
            if (dco) sb.push_back(mk_ev(RST_CYC, S_DCO, dco, div, trim));
            else begin
                sb.push_back(mk_ev(RST_CYC, S_ACQ, dco, div, trim));
                lk = 0; run = 0; bad = 0; nw = 0;
                foreach (cnts[k]) begin
                    rel = RST_CYC + WIN * (k + 1);
                    if (rel >= abort_rel) break;
                    err = (cnts[k] > expv) ? cnts[k] - expv : expv - cnts[k];
                    good = (err <= TOL);
                    if (!lk) begin
                        nw++;
                        run = good ? run + 1 : 0;
                        if (run == LOCK_WINS) begin
                            lk = 1; bad = 0;
                            sb.push_back(mk_ev(rel, S_LOCK, dco, div, trim));
                        end else if (nw == MAX_WINS) begin
                            sb.push_back(mk_ev(rel, S_FAULT, dco, div, trim));
                            break;
                        end
                    end else begin
                        bad = good ? 0 : bad + 1;
                        if (bad == LOSS_WINS) begin
                            lk = 0; run = 0; nw = 0;
                            sb.push_back(mk_ev(rel, S_ACQ, dco, div, trim));
                        end
                    end
                end
            end
        end
        sb.push_back(mk_ev(abort_rel, S_IDLE, dco, div, trim));

        foreach (cnts[k]) begin
            for (int i = 0; i < WIN; i++) w[i] = (i < cnts[k]);
            for (int i = WIN - 1; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = w[i]; w[i] = w[j]; w[j] = t;
            end
            for (int i = 0; i < WIN; i++) tk.push_back(w[i]);
        end

        @(posedge clock); #1;
        cfg_dco = dco; cfg_div = div; cfg_trim = trim; start = 1;
        fb_tick = 1'($urandom);
        e0 = cyc + 1;
        for (int r = 0; r <= abort_rel + 1; r++) begin
            @(posedge clock); #1;
            if (r == 1) begin
                cfg_dco = 1'($urandom); cfg_div = 8'($urandom); cfg_trim = 26'($urandom);
            end
            j = r - RST_CYC;
            fb_tick = (j >= 0 && j < tk.size()) ? tk[j] : 1'($urandom);
            if (r + 1 >= abort_rel) start = 0;
        end
        for (int k = 0; k < 300 && sb.size() > 0; k++) @(posedge clock);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending events, expected 0", sb.size());
            sb.delete();
        end
        fb_tick = 0;
        repeat (3) @(posedge clock);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int expv, n;
        logic [7:0] div;

        // Reset overrides an active start request.
        resetb = 0; start = 1; cfg_dco = 1; cfg_div = 8'hAA; cfg_trim = '1; fb_tick = 1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_dll_resetb", 64'(dll_resetb), 64'd0);
        chk("rst_dll_enable", 64'(dll_enable), 64'd0);
        chk("rst_dll_dco", 64'(dll_dco), 64'd0);
        chk("rst_dll_div", 64'(dll_div), 64'd0);
        chk("rst_dll_ext_trim", 64'(dll_ext_trim), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        @(posedge clock); #1;
        resetb = 1; start = 0; fb_tick = 0; cfg_dco = 0; cfg_div = 0; cfg_trim = 0;
        @(negedge clock);
        chk("idle_after_reset", 64'(state), 64'd0);
        prev_st = state;
        mon_en = 1;

        // DCO path; cfg changes during the run must not leak out.
        q.delete();
        run_scen(1'b1, 8'd8, 26'h0ABCDEF, q, 600);

        // Abort while still in HOLD.
        run_scen(1'b0, 8'd8, 26'h1234567, q, 5);

        // Tolerance edges, lock, isolated bad window, loss and relock.
        q = '{130, 130, 130, 131, 126, 130, 128, 129, 128, 0, 128, 0, 0, 128, 128, 128, 128};
        run_scen(1'b0, 8'd8, 26'h0000055, q, RST_CYC + WIN * q.size() + 77);

        // Acquire timeout.
        q.delete();
        for (int k = 0; k < MAX_WINS; k++) q.push_back(0);
        run_scen(1'b0, 8'd8, 26'h3FFFFFF, q, RST_CYC + WIN * MAX_WINS + 100);

        // Zero division ratio: only counts within TOL of zero are good.
        q = '{3, 0, 1, 2, 3, 2, 2, 2, 2};
        run_scen(1'b0, 8'd0, 26'h0000001, q, RST_CYC + WIN * q.size() + 10);

        // Abort in the middle of the first acquire window.
        q = '{128};
        run_scen(1'b0, 8'd8, 26'h0000AAA, q, RST_CYC + 100);

        // Randomized runs.
        for (int s = 0; s < 5; s++) begin
            div = 8'($urandom_range(0, 16));
            expv = int'(div) * 16;
            n = 20;
            q.delete();
            for (int k = 0; k < n; k++) begin
                int c;
                if ($urandom_range(0, 3) != 0)
                    c = expv + int'($urandom_range(0, 2 * TOL)) - TOL;
                else if ($urandom_range(0, 1) == 0)
                    c = expv + TOL + int'($urandom_range(1, 4));
                else
                    c = expv - TOL - int'($urandom_range(1, 4));
                if (c < 0) c = 0;
                if (c > WIN) c = WIN;
                q.push_back(c);
            end
            run_scen((s == 4), div, 26'($urandom), q, RST_CYC + WIN * n + int'($urandom_range(1, 255)));
        end

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
